// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if
//   Register-side bus of the UART receiver. It carries the read handshake
//   into the receive FIFO and the head entry plus status back out.
//   Ports (signals):
//     i_rd       pop the FIFO head (driven by the peripheral logic)
//     i_ovr_clr  clear the sticky overrun flag
//     o_wb_rdt   head data
//     o_perr     head parity error
//     o_ferr     head framing error
//     o_brk      head break
//     o_valid    FIFO not empty
//     o_count    FIFO occupancy
//     o_overrun  sticky: a frame was dropped because the FIFO was full
//   Modports: master = peripheral register logic, slave = receiver.
interface uart_rx_fifo_if #(
  parameter int BITS  = 8,
  parameter int CNT_W = 3
);
  logic             i_rd;
  logic             i_ovr_clr;
  logic [BITS-1:0]  o_wb_rdt;
  logic             o_perr;
  logic             o_ferr;
  logic             o_brk;
  logic             o_valid;
  logic [CNT_W-1:0] o_count;
  logic             o_overrun;

  modport master (
    output i_rd, i_ovr_clr,
    input  o_wb_rdt, o_perr, o_ferr, o_brk, o_valid, o_count, o_overrun
  );

  modport slave (
    input  i_rd, i_ovr_clr,
    output o_wb_rdt, o_perr, o_ferr, o_brk, o_valid, o_count, o_overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   UART receiver with runtime baud divisor, BITS data bits (LSB first),
//   optional even/odd parity, 3-sample majority voting, framing/parity/break
//   detection and a show-ahead receive FIFO with a sticky overrun flag.
//   Ports:
//     i_wb_clk        system clock
//     i_wb_rst_n      asynchronous active-low reset
//     i_wb_dat        raw serial RX line (asynchronous, idle high)
//     i_clks_per_bit  clocks per bit D (8 .. 2^DIV_W-1), latched per frame
//     i_parity        00/11 none, 01 even, 10 odd, latched per frame
//     bus             register-side FIFO bus (uart_rx_fifo_if.slave)
//     rx_active       receiver is not idle
module uart_rx_fifo #(
  parameter int BITS       = 8,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             i_wb_clk,
  input  logic             i_wb_rst_n,
  input  logic             i_wb_dat,
  input  logic [DIV_W-1:0] i_clks_per_bit,
  input  logic [1:0]       i_parity,
  uart_rx_fifo_if.slave    bus,
  output logic             rx_active
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(BITS);
  localparam int ENT_W = BITS + 3;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;

  state_t state_reg, state_next;

  // Input synchroniser; both flops reset to the idle line level.
  logic rx_meta_reg, rx_reg;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      rx_meta_reg <= 1'b1;
      rx_reg      <= 1'b1;
    end else begin
      rx_meta_reg <= i_wb_dat;
      rx_reg      <= rx_meta_reg;
    end
  end

  // Frame timing and datapath registers.
  logic [DIV_W-1:0] cnt_reg, div_reg;
  logic [1:0]       par_mode_reg;
  logic [IDX_W-1:0] idx_reg;
  logic [BITS-1:0]  data_reg;
  logic             s0_reg, s1_reg;
  logic             perr_reg, pbit_reg;

  logic [DIV_W-1:0] half;
  logic             at_s0, at_s1, at_dec, at_end;
  logic             maj, par_en;

  assign half   = div_reg >> 1;
  assign at_s0  = (cnt_reg == half - DIV_W'(1));
  assign at_s1  = (cnt_reg == half);
  assign at_dec = (cnt_reg == half + DIV_W'(1));
  assign at_end = (cnt_reg == div_reg - DIV_W'(1));
  // Third vote is the live synced bit on the decision cycle.
  assign maj    = (s0_reg & s1_reg) | (s0_reg & rx_reg) | (s1_reg & rx_reg);
  assign par_en = (par_mode_reg == 2'b01) || (par_mode_reg == 2'b10);

  logic             push;
  logic             ferr_now;
  logic             brk_now;
  logic [ENT_W-1:0] entry;

  always_comb begin
    state_next = state_reg;
    push       = 1'b0;
    ferr_now   = 1'b0;
    case (state_reg)
      IDLE:    if (!rx_reg) state_next = START;
      START: begin
        if (at_dec && maj)  state_next = IDLE;   // start bit was a glitch
        else if (at_end)    state_next = DATA;
      end
      DATA:    if (at_end && idx_reg == LAST_IDX) state_next = par_en ? PARITY : STOP;
      PARITY:  if (at_end) state_next = STOP;
      STOP: begin
        if (at_dec) begin
          push       = 1'b1;
          ferr_now   = ~maj;
          // Leave mid stop bit so a back-to-back start edge is not missed.
          state_next = maj ? IDLE : RECOVER;
        end
      end
      RECOVER: if (rx_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign brk_now = ferr_now && (data_reg == '0) && (!pbit_reg || !par_en);
  assign entry   = {brk_now, ferr_now, perr_reg, data_reg};

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      div_reg      <= '0;
      par_mode_reg <= 2'b00;
      idx_reg      <= '0;
      data_reg     <= '0;
      s0_reg       <= 1'b1;
      s1_reg       <= 1'b1;
      perr_reg     <= 1'b0;
      pbit_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;

      // Idle/recover hold the counter at zero so a new frame starts at 0.
      if (state_reg == IDLE || state_reg == RECOVER || at_end)
        cnt_reg <= '0;
      else
        cnt_reg <= cnt_reg + DIV_W'(1);

      if (state_reg == IDLE && !rx_reg) begin
        div_reg      <= i_clks_per_bit;
        par_mode_reg <= i_parity;
        perr_reg     <= 1'b0;
        pbit_reg     <= 1'b0;
      end

      if (at_s0) s0_reg <= rx_reg;
      if (at_s1) s1_reg <= rx_reg;

      if (state_reg == START) idx_reg <= '0;

      if (state_reg == DATA) begin
        if (at_dec) data_reg[idx_reg] <= maj;
        if (at_end) idx_reg <= idx_reg + IDX_W'(1);
      end

      if (state_reg == PARITY && at_dec) begin
        pbit_reg <= maj;
        // Even: error when overall XOR is 1; odd: error when it is 0.
        perr_reg <= (^data_reg) ^ maj ^ (par_mode_reg == 2'b10);
      end
    end
  end

  assign rx_active = (state_reg != IDLE);

  // Receive FIFO.
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             overrun_reg;
  logic             full, valid, pop, do_write;
  logic [ENT_W-1:0] head;

  assign valid    = (count_reg != '0);
  assign full     = (count_reg == CNT_W'(FIFO_DEPTH));
  assign pop      = bus.i_rd && valid;
  // When full, a same-cycle pop frees the head slot, which is exactly wr_ptr.
  assign do_write = push && (!full || pop);

  always_ff @(posedge i_wb_clk) begin
    if (do_write) mem[wr_ptr_reg] <= entry;
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_write) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)      rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({do_write, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      // Set has priority over clear.
      if (push && full && !pop) overrun_reg <= 1'b1;
      else if (bus.i_ovr_clr)   overrun_reg <= 1'b0;
    end
  end

  // Show-ahead head; forced to zero while empty so stale RAM never leaks out.
  assign head          = valid ? mem[rd_ptr_reg] : '0;
  assign bus.o_wb_rdt  = head[BITS-1:0];
  assign bus.o_perr    = head[BITS];
  assign bus.o_ferr    = head[BITS+1];
  assign bus.o_brk     = head[BITS+2];
  assign bus.o_valid   = valid;
  assign bus.o_count   = count_reg;
  assign bus.o_overrun = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo (BITS=8, FIFO_DEPTH=4).
//   Stimulus is driven on falling clock edges; outputs are sampled there too.
module tb_uart_rx_fifo;
  localparam int BITS       = 8;
  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 3;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b1;
  logic             pin   = 1'b1;
  logic [DIV_W-1:0] d     = 16'd16;
  logic [1:0]       par   = 2'b00;
  logic             rx_active;

  int total = 0;
  int bad   = 0;

  uart_rx_fifo_if #(.BITS(BITS), .CNT_W(CNT_W)) bus ();

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .BITS(BITS), .DIV_W(DIV_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .i_wb_clk(clk),
    .i_wb_rst_n(rst_n),
    .i_wb_dat(pin),
    .i_clks_per_bit(d),
    .i_parity(par),
    .bus(bus),
    .rx_active(rx_active)
  );

  // Drive one frame starting at a falling edge. With pop_at_stop set, i_rd is
  // raised for the single cycle whose rising edge takes the stop-bit decision
  // (pin-to-decision offset: 2 sync + 1 idle detect + H+2 into the stop bit).
  task automatic send_frame(input logic [7:0] data, input logic use_par,
                            input logic pbit, input logic pop_at_stop);
    int pop_k;
    pop_k = int'(d >> 1) + 4;
    pin = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < BITS; i++) begin
      pin = data[i];
      repeat (d) @(negedge clk);
    end
    if (use_par) begin
      pin = pbit;
      repeat (d) @(negedge clk);
    end
    pin = 1'b1;
    for (int k = 0; k < int'(d); k++) begin
      bus.i_rd = (pop_at_stop && k == pop_k);
      @(negedge clk);
    end
    bus.i_rd = 1'b0;
    $display("sent frame data=%h par_mode=%b pbit=%b d=%0d", data, par, pbit, d);
  endtask

  task automatic pop_one();
    $display("pop data=%h perr=%b ferr=%b brk=%b count=%0d",
             bus.o_wb_rdt, bus.o_perr, bus.o_ferr, bus.o_brk, bus.o_count);
    bus.i_rd = 1'b1;
    @(negedge clk);
    bus.i_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_valid); end
    total++; if (bus.o_count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", bus.o_count); end
    total++; if (bus.o_wb_rdt !== 8'h00) begin bad++; $display("FAIL rst_rdt got=%h want=00", bus.o_wb_rdt); end
    total++; if ({bus.o_brk, bus.o_ferr, bus.o_perr} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {bus.o_brk, bus.o_ferr, bus.o_perr}); end
    total++; if (bus.o_overrun !== 1'b0 || rx_active !== 1'b0) begin bad++; $display("FAIL rst_ovr_active got=%b%b want=00", bus.o_overrun, rx_active); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic();
    d = 16'd16; par = 2'b00;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_wb_rdt !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", bus.o_wb_rdt); end
    total++; if ({bus.o_brk, bus.o_ferr, bus.o_perr} !== 3'b000) begin bad++; $display("FAIL basic_flags got=%b want=000", {bus.o_brk, bus.o_ferr, bus.o_perr}); end
    total++; if (bus.o_count !== 3'd1 || bus.o_valid !== 1'b1) begin bad++; $display("FAIL basic_count got=%0d/%b want=1/1", bus.o_count, bus.o_valid); end
    pop_one();
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL basic_pop_valid got=%b want=0", bus.o_valid); end
    // Pop on an empty FIFO must be ignored.
    pop_one();
    total++; if (bus.o_count !== 3'd0) begin bad++; $display("FAIL underflow_count got=%0d want=0", bus.o_count); end
  endtask

  task automatic test_parity();
    d = 16'd16;
    par = 2'b01;
    send_frame(8'h03, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_perr !== 1'b0 || bus.o_wb_rdt !== 8'h03) begin bad++; $display("FAIL even_ok got=%b/%h want=0/03", bus.o_perr, bus.o_wb_rdt); end
    pop_one();
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_perr !== 1'b1 || bus.o_wb_rdt !== 8'h03) begin bad++; $display("FAIL even_bad got=%b/%h want=1/03", bus.o_perr, bus.o_wb_rdt); end
    total++; if (bus.o_ferr !== 1'b0 || bus.o_brk !== 1'b0) begin bad++; $display("FAIL even_bad_flags got=%b%b want=00", bus.o_ferr, bus.o_brk); end
    pop_one();
    par = 2'b10;
    send_frame(8'h03, 1'b1, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_perr !== 1'b0 || bus.o_wb_rdt !== 8'h03) begin bad++; $display("FAIL odd_ok got=%b/%h want=0/03", bus.o_perr, bus.o_wb_rdt); end
    pop_one();
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_perr !== 1'b0 || bus.o_wb_rdt !== 8'h07) begin bad++; $display("FAIL odd_ok7 got=%b/%h want=0/07", bus.o_perr, bus.o_wb_rdt); end
    pop_one();
    par = 2'b00;
  endtask

  task automatic test_glitch();
    int act;
    act = 0;
    d = 16'd16; par = 2'b00;
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL glitch_pre_active got=%b want=0", rx_active); end
    pin = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 3) pin = 1'b1;
      if (rx_active === 1'b1) act++;
    end
    $display("glitch active_cycles=%0d", act);
    // Start detected 3 edges after the pin falls, rejected at cnt=H+1 (9 edges later).
    total++; if (act != 10) begin bad++; $display("FAIL glitch_window got=%0d want=10", act); end
    total++; if (rx_active !== 1'b0 || bus.o_count !== 3'd0) begin bad++; $display("FAIL glitch_after got=%b/%0d want=0/0", rx_active, bus.o_count); end
  endtask

  task automatic test_break();
    d = 16'd16; par = 2'b00;
    pin = 1'b0;
    repeat (11 * 16) @(negedge clk);
    total++; if (bus.o_count !== 3'd1 || rx_active !== 1'b1) begin bad++; $display("FAIL brk_low got=%0d/%b want=1/1", bus.o_count, rx_active); end
    repeat (16) @(negedge clk);
    pin = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (rx_active !== 1'b0) begin bad++; $display("FAIL brk_idle got=%b want=0", rx_active); end
    total++; if (bus.o_wb_rdt !== 8'h00 || {bus.o_brk, bus.o_ferr, bus.o_perr} !== 3'b110) begin bad++; $display("FAIL brk_entry got=%h/%b want=00/110", bus.o_wb_rdt, {bus.o_brk, bus.o_ferr, bus.o_perr}); end
    repeat (48) @(negedge clk);
    total++; if (bus.o_count !== 3'd1) begin bad++; $display("FAIL brk_single got=%0d want=1", bus.o_count); end
    pop_one();
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_count !== 3'd1 || bus.o_wb_rdt !== 8'h3C || bus.o_ferr !== 1'b0) begin bad++; $display("FAIL brk_recover got=%0d/%h/%b want=1/3c/0", bus.o_count, bus.o_wb_rdt, bus.o_ferr); end
    pop_one();
  endtask

  task automatic test_overrun();
    logic [7:0] want;
    d = 16'd16; par = 2'b00;
    for (int i = 1; i <= 5; i++) send_frame(8'(i * 8'h11), 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_count !== 3'd4) begin bad++; $display("FAIL ovr_count got=%0d want=4", bus.o_count); end
    total++; if (bus.o_overrun !== 1'b1) begin bad++; $display("FAIL ovr_flag got=%b want=1", bus.o_overrun); end
    for (int i = 1; i <= 4; i++) begin
      want = 8'(i * 8'h11);
      total++; if (bus.o_wb_rdt !== want) begin bad++; $display("FAIL ovr_pop%0d got=%h want=%h", i, bus.o_wb_rdt, want); end
      pop_one();
    end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL ovr_empty got=%b want=0", bus.o_valid); end
    bus.i_ovr_clr = 1'b1;
    @(negedge clk);
    bus.i_ovr_clr = 1'b0;
    total++; if (bus.o_overrun !== 1'b0) begin bad++; $display("FAIL ovr_clr got=%b want=0", bus.o_overrun); end
    // Fill, then pop exactly on the push edge of a fifth frame.
    for (int i = 1; i <= 4; i++) send_frame(8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    send_frame(8'h65, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (bus.o_count !== 3'd4 || bus.o_overrun !== 1'b0) begin bad++; $display("FAIL coinc_state got=%0d/%b want=4/0", bus.o_count, bus.o_overrun); end
    for (int i = 2; i <= 5; i++) begin
      want = 8'(8'h60 + i);
      total++; if (bus.o_wb_rdt !== want) begin bad++; $display("FAIL coinc_pop%0d got=%h want=%h", i, bus.o_wb_rdt, want); end
      pop_one();
    end
    total++; if (bus.o_count !== 3'd0) begin bad++; $display("FAIL coinc_empty got=%0d want=0", bus.o_count); end
  endtask

  task automatic test_reset_midframe();
    d = 16'd16; par = 2'b00;
    send_frame(8'h77, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    pin = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pin = 1'b1;
      repeat (16) @(negedge clk);
    end
    pin = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++; if (bus.o_valid !== 1'b0 || bus.o_count !== 3'd0) begin bad++; $display("FAIL mid_rst_fifo got=%b/%0d want=0/0", bus.o_valid, bus.o_count); end
    total++; if (bus.o_wb_rdt !== 8'h00 || rx_active !== 1'b0) begin bad++; $display("FAIL mid_rst_out got=%h/%b want=00/0", bus.o_wb_rdt, rx_active); end
    pin = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    d = 16'd24;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    total++; if (bus.o_wb_rdt !== 8'h5A || bus.o_count !== 3'd1) begin bad++; $display("FAIL d24_frame got=%h/%0d want=5a/1", bus.o_wb_rdt, bus.o_count); end
    total++; if ({bus.o_brk, bus.o_ferr, bus.o_perr} !== 3'b000) begin bad++; $display("FAIL d24_flags got=%b want=000", {bus.o_brk, bus.o_ferr, bus.o_perr}); end
    pop_one();
  endtask

  initial begin
    bus.i_rd      = 1'b0;
    bus.i_ovr_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
